sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 8;

  // Pointer width: address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port, one registered read port, contents never reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_array [0:(1<<ADDR_W)-1];

  // Write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_array[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: wrap-bit pointers, registered read data, error pulses.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_TH = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   r_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(ALMOST_FULL_TH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  rd_seen_reg;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                 (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

  // A read frees a slot on the same edge, so a full FIFO still takes a write.
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);

  assign count       = wr_ptr_reg - rd_ptr_reg;
  assign almost_full = (count >= AF_TH);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // The storage read register has no reset; until the first accepted read
  // after reset the output is forced to zero, which also makes reset
  // take effect on data_out immediately.
  assign data_out = rd_seen_reg ? mem_rd_data : '0;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (mem_rd_data)
  );

  // Pointer advance on accepted transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Registered one-cycle pulses for rejected requests, plus read-seen flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      rd_seen_reg   <= 1'b0;
    end else begin
      overflow_reg  <= w_en && !wr_acc;
      underflow_reg <= r_en && empty;
      if (rd_acc) begin
        rd_seen_reg <= 1'b1;
      end
    end
  end

endmodule
